// File: rtl/fp_matmul_scheduler.sv
// Sequences a 2x2 single-precision matrix multiply over one shared multiplier and one shared adder.
// Optional watchdog on the wait states: define FP_MATMUL_TIMEOUT_EN (adds output_Error).
module fp_matmul_scheduler #(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic        input_Clk,
   input  logic        input_Reset,
   input  logic        input_Stable,
   input  logic [31:0] input_A11,
   input  logic [31:0] input_A12,
   input  logic [31:0] input_A21,
   input  logic [31:0] input_A22,
   input  logic [31:0] input_B11,
   input  logic [31:0] input_B12,
   input  logic [31:0] input_B21,
   input  logic [31:0] input_B22,
   output logic        output_AB_Ack,
   output logic [31:0] output_C11,
   output logic [31:0] output_C12,
   output logic [31:0] output_C21,
   output logic [31:0] output_C22,
   output logic        output_Stable,
   input  logic        input_C_Ack,
   output logic        output_Busy,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic        mul_stb,
   input  logic [31:0] mul_z,
   input  logic        mul_z_stb,
   output logic        mul_z_ack,
   output logic [31:0] add_n1,
   output logic [31:0] add_n2,
   output logic        add_load,
   input  logic [31:0] add_result,
   input  logic        add_ready,
   output logic        add_ack
`ifdef FP_MATMUL_TIMEOUT_EN
   ,
   output logic        output_Error
`endif
);

   typedef enum logic [3:0] {
      IDLE, MUL0, MUL0_ACK, MUL1, MUL1_ACK, ADD, ADD_ACK, NEXT, DONE
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] a11, a12, a21, a22, b11, b12, b21, b22;
   logic [31:0] p0, p1;
   logic [1:0]  idx;
   logic        ack_q;
   logic [31:0] c11, c12, c21, c22;
   logic        wd_expire;
   logic [31:0] a_i1, a_i2, b_1j, b_2j;

   // Row i = idx[1], column j = idx[0]
   assign a_i1 = idx[1] ? a21 : a11;
   assign a_i2 = idx[1] ? a22 : a12;
   assign b_1j = idx[0] ? b12 : b11;
   assign b_2j = idx[0] ? b22 : b21;

`ifdef FP_MATMUL_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wd_cnt;
   logic             wait_state;
   logic             err_q;

   assign wait_state = (state == MUL0) || (state == MUL1) || (state == ADD);
   // Fires on the last permitted wait cycle so the abort lands exactly TIMEOUT_CYCLES after entry
   assign wd_expire  = wait_state && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign output_Error = err_q;

   always_ff @(posedge input_Clk) begin
      if (input_Reset) begin
         wd_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state_nxt != state || !wait_state)
            wd_cnt <= '0;
         else
            wd_cnt <= wd_cnt + CNT_W'(1);
         if (wd_expire)
            err_q <= 1'b1;
         else if (state == IDLE && input_Stable)
            err_q <= 1'b0;
      end
   end
`else
   assign wd_expire = 1'b0;
`endif

   always_ff @(posedge input_Clk) begin
      if (input_Reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (input_Stable) state_nxt = MUL0;
         MUL0:     if (wd_expire) state_nxt = IDLE;
                   else if (mul_z_stb) state_nxt = MUL0_ACK;
         MUL0_ACK: state_nxt = MUL1;
         MUL1:     if (wd_expire) state_nxt = IDLE;
                   else if (mul_z_stb) state_nxt = MUL1_ACK;
         MUL1_ACK: state_nxt = ADD;
         ADD:      if (wd_expire) state_nxt = IDLE;
                   else if (add_ready) state_nxt = ADD_ACK;
         ADD_ACK:  state_nxt = NEXT;
         NEXT:     state_nxt = (idx == 2'd3) ? DONE : MUL0;
         DONE:     if (input_C_Ack) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mul_a         = '0;
      mul_b         = '0;
      mul_stb       = 1'b0;
      mul_z_ack     = 1'b0;
      add_n1        = '0;
      add_n2        = '0;
      add_load      = 1'b0;
      add_ack       = 1'b0;
      output_Stable = 1'b0;
      case (state)
         MUL0: begin
            mul_stb = 1'b1;
            mul_a   = a_i1;
            mul_b   = b_1j;
         end
         MUL1: begin
            mul_stb = 1'b1;
            mul_a   = a_i2;
            mul_b   = b_2j;
         end
         MUL0_ACK, MUL1_ACK: mul_z_ack = 1'b1;
         ADD: begin
            add_load = 1'b1;
            add_n1   = p0;
            add_n2   = p1;
         end
         ADD_ACK: add_ack = 1'b1;
         DONE:    output_Stable = 1'b1;
         default: ;
      endcase
   end

   assign output_Busy   = (state != IDLE);
   assign output_AB_Ack = ack_q;
   assign output_C11    = c11;
   assign output_C12    = c12;
   assign output_C21    = c21;
   assign output_C22    = c22;

   // Operand latch, partial products and result matrix; strobes outside their wait state never reach these
   always_ff @(posedge input_Clk) begin
      if (input_Reset) begin
         {a11, a12, a21, a22} <= '0;
         {b11, b12, b21, b22} <= '0;
         {c11, c12, c21, c22} <= '0;
         p0    <= '0;
         p1    <= '0;
         idx   <= '0;
         ack_q <= 1'b0;
      end else begin
         ack_q <= (state == IDLE) && input_Stable;
         case (state)
            IDLE: if (input_Stable) begin
               a11 <= input_A11;
               a12 <= input_A12;
               a21 <= input_A21;
               a22 <= input_A22;
               b11 <= input_B11;
               b12 <= input_B12;
               b21 <= input_B21;
               b22 <= input_B22;
               idx <= 2'd0;
            end
            MUL0: if (mul_z_stb && !wd_expire) p0 <= mul_z;
            MUL1: if (mul_z_stb && !wd_expire) p1 <= mul_z;
            ADD: if (add_ready && !wd_expire) begin
               case (idx)
                  2'd0: c11 <= add_result;
                  2'd1: c12 <= add_result;
                  2'd2: c21 <= add_result;
                  default: c22 <= add_result;
               endcase
            end
            NEXT: if (idx != 2'd3) idx <= idx + 2'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_matmul_scheduler.sv
// Bench for fp_matmul_scheduler: behavioural multiplier/adder, matrix-level scoreboard and directed cases.
module tb_fp_matmul_scheduler;

   localparam int LM  = 3;
   localparam int LA  = 2;
   localparam int LAT = 4 * (8 + 2 * LM + LA);
`ifdef FP_MATMUL_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 1023;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, stb_in, c_ack;
   logic [31:0] A[4];
   logic [31:0] B[4];
   logic [31:0] C[4];
   logic        output_AB_Ack, output_Stable, output_Busy;
   logic [31:0] mul_a, mul_b, mul_z, add_n1, add_n2, add_result;
   logic        mul_stb, mul_z_stb, mul_z_ack, add_load, add_ready, add_ack;
   logic        mul_en, mul_glitch, add_glitch;
`ifdef FP_MATMUL_TIMEOUT_EN
   logic        output_Error;
`endif

   fp_matmul_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
      .input_Clk(clk), .input_Reset(rst), .input_Stable(stb_in),
      .input_A11(A[0]), .input_A12(A[1]), .input_A21(A[2]), .input_A22(A[3]),
      .input_B11(B[0]), .input_B12(B[1]), .input_B21(B[2]), .input_B22(B[3]),
      .output_AB_Ack(output_AB_Ack),
      .output_C11(C[0]), .output_C12(C[1]), .output_C21(C[2]), .output_C22(C[3]),
      .output_Stable(output_Stable), .input_C_Ack(c_ack), .output_Busy(output_Busy),
      .mul_a(mul_a), .mul_b(mul_b), .mul_stb(mul_stb), .mul_z(mul_z),
      .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
      .add_n1(add_n1), .add_n2(add_n2), .add_load(add_load), .add_result(add_result),
      .add_ready(add_ready), .add_ack(add_ack)
`ifdef FP_MATMUL_TIMEOUT_EN
      , .output_Error(output_Error)
`endif
   );

   function automatic real sp2r(input logic [31:0] v);
      real m;
      int  e;
      if (v[30:23] == 8'd0) return 0.0;
      m = 1.0 + real'(v[22:0]) / 8388608.0;
      e = int'(v[30:23]) - 127;
      while (e > 0) begin m = m * 2.0; e--; end
      while (e < 0) begin m = m / 2.0; e++; end
      return v[31] ? -m : m;
   endfunction

   function automatic logic [31:0] r2sp(input real x);
      logic s;
      int   e;
      real  m;
      if (x == 0.0) return 32'd0;
      s = (x < 0.0);
      m = s ? -x : x;
      e = 127;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0)  begin m = m * 2.0; e--; end
      return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
   endfunction

   // Shared-unit models: multiplier answers in the Lm-th cycle of its strobe; the adder registers
   // its operands first, so ready lands La+1 cycles after load rises.
   int mcnt = 0;
   int acnt = 0;
   always @(posedge clk) begin
      mcnt <= mul_stb ? mcnt + 1 : 0;
      acnt <= add_load ? acnt + 1 : 0;
   end
   assign mul_z_stb = (mul_en && mul_stb && mcnt == LM) || mul_glitch;
   assign add_ready = (add_load && acnt == LA + 1) || add_glitch;
   always_comb mul_z = r2sp(sp2r(mul_a) * sp2r(mul_b));
   always_comb add_result = r2sp(sp2r(add_n1) + sp2r(add_n2));

   int tests = 0;
   int fails = 0;

   task automatic chk1(input string nm, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: acceptance, fixed latency, expected matrix and operand sequences
   int          cyc = 0;
   int          ack_at = -100;
   int          done_at = -100;
   bit          mbusy = 1'b0;
   bit          merr = 1'b0;
   logic [31:0] expC[4];
   logic [63:0] mq[$];
   logic [63:0] aq[$];

   always @(posedge clk) begin
      if (rst) begin
         mbusy = 1'b0;
         merr  = 1'b0;
         mq.delete();
         aq.delete();
      end else if (!mbusy) begin
         if (stb_in) begin
            mbusy   = 1'b1;
            merr    = 1'b0;
            ack_at  = cyc + 1;
            done_at = cyc + 1 + LAT;
            mq.delete();
            aq.delete();
            for (int k = 0; k < 4; k++) begin
               int i, j;
               real r0, r1;
               i  = k / 2;
               j  = k % 2;
               r0 = sp2r(A[2*i]) * sp2r(B[j]);
               r1 = sp2r(A[2*i+1]) * sp2r(B[2+j]);
               mq.push_back({A[2*i], B[j]});
               mq.push_back({A[2*i+1], B[2+j]});
               aq.push_back({r2sp(r0), r2sp(r1)});
               expC[k] = r2sp(r0 + r1);
            end
         end
`ifdef FP_MATMUL_TIMEOUT_EN
      end else if (!mul_en && cyc == ack_at + TO - 1) begin
         mbusy = 1'b0;
         merr  = 1'b1;
`endif
      end else if (cyc >= done_at && c_ack) begin
         mbusy = 1'b0;
      end
      cyc++;
   end

   bit chk_en = 1'b0;
   always @(negedge clk) begin
      if (chk_en) begin
         logic exp_st;
         exp_st = mbusy && (cyc >= done_at);
         chk1("busy", output_Busy, mbusy);
         chk1("ab_ack", output_AB_Ack, cyc == ack_at);
         chk1("c_stable", output_Stable, exp_st);
         chk1("stb_load_excl", mul_stb && add_load, 1'b0);
`ifdef FP_MATMUL_TIMEOUT_EN
         chk1("error", output_Error, merr);
`endif
         if (exp_st)
            for (int k = 0; k < 4; k++) chk32("c_model", C[k], expC[k]);
         if (mul_stb && mul_z_stb) begin
            if (mq.size() == 0) chk1("mul_unexpected", 1'b1, 1'b0);
            else chk64("mul_operands", {mul_a, mul_b}, mq.pop_front());
         end
         if (add_load && add_ready) begin
            if (aq.size() == 0) chk1("add_unexpected", 1'b1, 1'b0);
            else chk64("add_operands", {add_n1, add_n2}, aq.pop_front());
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_ab(input logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3);
      A[0] = a0; A[1] = a1; A[2] = a2; A[3] = a3;
      B[0] = b0; B[1] = b1; B[2] = b2; B[3] = b3;
   endtask

   task automatic wait_stable(input string nm, output int n);
      n = 0;
      while (!output_Stable && n < 300) begin tick(); n++; end
      if (!output_Stable) chk1({nm, "_timeout"}, 1'b0, 1'b1);
   endtask

   task automatic release_result();
      c_ack = 1'b1;
      tick();
      c_ack = 1'b0;
      chk1("stable_after_cack", output_Stable, 1'b0);
      chk1("busy_after_cack", output_Busy, 1'b0);
   endtask

   initial begin
      int n, nacks;
      logic [31:0] snap[4];
      rst = 1'b1; stb_in = 1'b0; c_ack = 1'b0;
      mul_en = 1'b1; mul_glitch = 1'b0; add_glitch = 1'b0;
      set_ab('0, '0, '0, '0, '0, '0, '0, '0);
      tick(); tick();
      chk_en = 1'b1;
      for (int k = 0; k < 4; k++) chk32("reset_c", C[k], 32'd0);
      chk1("reset_stable", output_Stable, 1'b0);
      chk1("reset_mul_stb", mul_stb, 1'b0);
      chk1("reset_add_load", add_load, 1'b0);

      // A=[1,2;3,4], B=[5,6;7,8] with input_Stable held high throughout
      set_ab(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000);
      rst = 1'b0;
      stb_in = 1'b1;
      n = 0;
      while (!output_AB_Ack && n < 10) begin tick(); n++; end
      chk1("first_ack_seen", output_AB_Ack, 1'b1);
      A[0] = 32'h41200000;
      B[3] = 32'h42C80000;
      nacks = 1;
      n = 0;
      while (!output_Stable && n < 300) begin
         tick(); n++;
         if (output_AB_Ack) nacks++;
      end
      chk32("latency", 32'(n), 32'(LAT));
      chk32("C11_lit", C[0], 32'h41980000);
      chk32("C12_lit", C[1], 32'h41B00000);
      chk32("C21_lit", C[2], 32'h422C0000);
      chk32("C22_lit", C[3], 32'h42480000);
      for (int k = 0; k < 4; k++) snap[k] = C[k];
      for (int t = 0; t < 20; t++) begin
         mul_glitch = (t == 5);
         add_glitch = (t == 6);
         tick();
         if (output_AB_Ack) nacks++;
         chk1("hold_stable", output_Stable, 1'b1);
         for (int k = 0; k < 4; k++) chk32("hold_c", C[k], snap[k]);
      end
      mul_glitch = 1'b0;
      add_glitch = 1'b0;
      chk32("single_ack", 32'(nacks), 32'd1);
      stb_in = 1'b0;
      release_result();

      // Abort with reset during the third ADD (idx=2)
      set_ab(32'h40000000, 32'h00000000, 32'h00000000, 32'h40400000,
             32'h40000000, 32'h3F800000, 32'h3F800000, 32'h40000000);
      stb_in = 1'b1; tick(); stb_in = 1'b0;
      begin
         int ph;
         logic prev;
         ph = 0; prev = 1'b0; n = 0;
         while (!(ph == 3 && add_load) && n < 300) begin
            if (add_load && !prev) ph++;
            prev = add_load;
            if (!(ph == 3 && add_load)) begin tick(); n++; end
         end
         chk1("third_add_reached", add_load, 1'b1);
      end
      rst = 1'b1;
      tick();
      chk1("abort_add_load", add_load, 1'b0);
      chk1("abort_mul_stb", mul_stb, 1'b0);
      chk1("abort_add_ack", add_ack, 1'b0);
      chk1("abort_mul_z_ack", mul_z_ack, 1'b0);
      chk1("abort_busy", output_Busy, 1'b0);
      for (int k = 0; k < 4; k++) chk32("abort_c", C[k], 32'd0);
      rst = 1'b0;

      // Identity times identity
      set_ab(32'h3F800000, 32'h0, 32'h0, 32'h3F800000, 32'h3F800000, 32'h0, 32'h0, 32'h3F800000);
      stb_in = 1'b1; tick(); stb_in = 1'b0;
      wait_stable("ident", n);
      chk32("I_C11", C[0], 32'h3F800000);
      chk32("I_C12", C[1], 32'h00000000);
      chk32("I_C21", C[2], 32'h00000000);
      chk32("I_C22", C[3], 32'h3F800000);
      release_result();

`ifdef FP_MATMUL_TIMEOUT_EN
      // Multiplier never answers: watchdog abort, then a good transaction clears the error
      mul_en = 1'b0;
      stb_in = 1'b1; tick(); stb_in = 1'b0;
      chk1("to_ack", output_AB_Ack, 1'b1);
      n = 0;
      while (!output_Error && n < 100) begin tick(); n++; end
      chk32("to_cycles", 32'(n), 32'(TO));
      chk1("to_idle", output_Busy, 1'b0);
      chk1("to_mul_stb", mul_stb, 1'b0);
      mul_en = 1'b1;
      set_ab(32'h40000000, 32'h0, 32'h0, 32'h40000000, 32'h40000000, 32'h0, 32'h0, 32'h40000000);
      stb_in = 1'b1; tick(); stb_in = 1'b0;
      chk1("err_cleared", output_Error, 1'b0);
      wait_stable("after_to", n);
      chk32("to_C11", C[0], 32'h40800000);
      release_result();
`endif

      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fp_matmul_scheduler.md
FP_MATMUL_SCHEDULER -- requirements
Module: fp_matmul_scheduler

Interface
REQ-001 The parameter TIMEOUT_CYCLES SHALL default to 1023 and set the watchdog limit in cycles per shared-unit transaction.
REQ-002 input_Clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 input_Reset  in  1  SHALL be the reset, synchronous and active-high.
REQ-004 input_Stable  in  1  SHALL indicate the operand matrices are valid.
REQ-005 input_A11..input_A22, input_B11..input_B22  in  32 each  SHALL carry IEEE-754 single-precision operands.
REQ-006 output_AB_Ack  out  1  SHALL be a one-cycle operand-accepted pulse.
REQ-007 output_C11..output_C22  out  32 each  SHALL carry the result matrix.
REQ-008 output_Stable  out  1  SHALL indicate the result is valid.
REQ-009 input_C_Ack  in  1  SHALL be the consumer's result acknowledge.
REQ-010 output_Busy  out  1  SHALL be high in every state except IDLE.
REQ-011 mul_a, mul_b  out  32  SHALL carry the operands for the shared multiplier; mul_stb  out  1  SHALL be its operand strobe; mul_z  in  32  SHALL be its product; mul_z_stb  in  1  SHALL be its product strobe; mul_z_ack  out  1  SHALL be the product acknowledge.
REQ-012 add_n1, add_n2  out  32  SHALL carry the adder operands; add_load  out  1  SHALL be the adder load; add_result  in  32  SHALL be its result; add_ready  in  1  SHALL be its result-ready; add_ack  out  1  SHALL be the result acknowledge.

Function
REQ-013 The FSM SHALL have the states IDLE, MUL0, MUL0_ACK, MUL1, MUL1_ACK, ADD, ADD_ACK, NEXT and DONE.
REQ-014 In IDLE with input_Stable=1, the block SHALL latch all eight operands, pulse output_AB_Ack for one cycle, clear element index idx (2 bits) to 0 and enter MUL0 on the next edge.
REQ-015 Element idx SHALL map 0..3 to C11, C12, C21, C22, with row i=idx[1] and column j=idx[0].
REQ-016 MUL0 SHALL drive mul_a=A(i,1) and mul_b=B(1,j) and hold mul_stb=1 until mul_z_stb=1, then capture mul_z into p0 and enter MUL0_ACK.
REQ-017 MUL0_ACK SHALL drive mul_z_ack=1 for exactly one cycle with mul_stb=0, then enter MUL1.
REQ-018 MUL1 and MUL1_ACK SHALL behave the same way using A(i,2) and B(2,j), capturing the product into p1.
REQ-019 ADD SHALL drive add_n1=p0 and add_n2=p1 and hold add_load=1 until add_ready=1, then write add_result to the output_Cij selected by idx and enter ADD_ACK.
REQ-020 ADD_ACK SHALL pulse add_ack for one cycle; NEXT SHALL then enter DONE if idx=3, else increment idx and enter MUL0.
REQ-021 DONE SHALL hold output_Stable=1 and output_C* constant until input_C_Ack=1, then enter IDLE with output_Stable=0 on the next edge.
REQ-022 input_Stable while not in IDLE SHALL be ignored, with no ack and no change to the latched operands.
REQ-023 Latched operands SHALL stay unchanged from acceptance until DONE exits, even if input_A*/input_B* change.
REQ-024 A result strobe (mul_z_stb or add_ready) arriving outside its own wait state SHALL be ignored.
REQ-025 mul_stb and add_load SHALL never both be high in the same cycle.
REQ-026 Total latency from output_AB_Ack to output_Stable SHALL be 4*(8 + 2*Lm + La) cycles, where Lm and La are the strobe-to-result latencies of the multiplier and adder.

Reset
REQ-027 While input_Reset=1 at a clock edge, the block SHALL enter IDLE and set all outputs, p0, p1, idx and the latched operands to 0.
REQ-028 Reset asserted mid-operation SHALL abort the computation, and mul_stb, add_load and both acks SHALL be low from the next edge.

Configuration
REQ-029 With FP_MATMUL_TIMEOUT_EN defined, a cycle counter SHALL run in MUL0, MUL1 and ADD and clear on each state entry.
REQ-030 With FP_MATMUL_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL drive mul_stb and add_load low, set sticky output output_Error=1 and go to IDLE; output_Error SHALL clear only on reset or on the next accepted input_Stable.
REQ-031 Without FP_MATMUL_TIMEOUT_EN defined, the output_Error port and the counter SHALL be absent, and wait states SHALL wait indefinitely.

Verification
REQ-032 A=[1,2;3,4] (0x3F800000, 0x40000000, 0x40400000, 0x40800000) and B=[5,6;7,8] (0x40A00000, 0x40C00000, 0x40E00000, 0x41000000) -> C11=0x41980000, C12=0x41B00000, C21=0x422C0000, C22=0x42480000 with output_Stable=1.
REQ-033 Models with Lm=3 and La=2 and input_Stable held high -> exactly one output_AB_Ack pulse, output_Stable at cycle 4*(8+6+2)=64 after the ack, and no second acceptance until input_C_Ack.
REQ-034 input_C_Ack held low for 20 cycles in DONE -> outputs constant for those 20 cycles; ack=1 -> IDLE and output_Stable=0 next cycle.
REQ-035 Reset asserted in the idx=2 ADD state -> all outputs 0 and add_load=0 next edge; a fresh A=I, B=I (identity) transaction -> C=I (0x3F800000 on the diagonal, 0 elsewhere).
REQ-036 With FP_MATMUL_TIMEOUT_EN and TIMEOUT_CYCLES=16, multiplier never strobing -> output_Error=1 at cycle 16 of MUL0 and the state returns to IDLE.
